// File: rtl/alu_exec_stage.sv
// Registered execute stage: an operand register feeding a 32-bit combinational ALU,
// followed by an in-order result queue with credit-based input flow control.

module ALU (
   input  logic [31:0] operandA,
   input  logic [31:0] operandB,
   input  logic [2:0]  command,
   output logic [31:0] result,
   output logic        carryout,
   output logic        zero,
   output logic        overflow
);

   logic [32:0] add_full;
   logic [32:0] sub_full;
   logic        add_ovf;
   logic        sub_ovf;

   assign add_full = {1'b0, operandA} + {1'b0, operandB};
   assign sub_full = {1'b0, operandA} + {1'b0, ~operandB} + 33'd1;
   assign add_ovf  = (operandA[31] == operandB[31]) && (add_full[31] != operandA[31]);
   assign sub_ovf  = (operandA[31] != operandB[31]) && (sub_full[31] != operandA[31]);

   // SLT is a signed compare taken from the subtractor sign corrected by overflow
   always_comb begin
      result   = '0;
      carryout = 1'b0;
      overflow = 1'b0;
      case (command)
         3'b000: begin result = add_full[31:0]; carryout = add_full[32]; overflow = add_ovf; end
         3'b001: begin result = sub_full[31:0]; carryout = sub_full[32]; overflow = sub_ovf; end
         3'b010: result = operandA ^ operandB;
         3'b011: result = {31'd0, sub_full[31] ^ sub_ovf};
         3'b100: result = operandA & operandB;
         3'b101: result = ~(operandA & operandB);
         3'b110: result = ~(operandA | operandB);
         default: result = operandA | operandB;
      endcase
   end

   assign zero = (result == 32'd0);

endmodule

module alu_exec_stage #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_cmd,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [3:0]  in_tag,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_carryout,
   output logic        out_zero,
   output logic        out_overflow,
   output logic [3:0]  out_tag,
   output logic        sticky_overflow,
   input  logic        sticky_clear,
   output logic [15:0] op_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0] result;
      logic        carryout;
      logic        zero;
      logic        overflow;
      logic [3:0]  tag;
   } entry_t;

   logic          s1_valid;
   logic [2:0]    s1_cmd;
   logic [31:0]   s1_a;
   logic [31:0]   s1_b;
   logic [3:0]    s1_tag;
   logic [31:0]   alu_result;
   logic          alu_carryout;
   logic          alu_zero;
   logic          alu_overflow;
   logic          is_arith;
   entry_t        push_entry;
   entry_t        head;
   entry_t        queue_mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          accept;
   logic          push;
   logic          pop;

   ALU alu_core (
      .operandA (s1_a),
      .operandB (s1_b),
      .command  (s1_cmd),
      .result   (alu_result),
      .carryout (alu_carryout),
      .zero     (alu_zero),
      .overflow (alu_overflow)
   );

   // Credit counts the operand register too, so a push can never find the queue full
   assign in_ready  = !reset && (({1'b0, count} + {{CW{1'b0}}, s1_valid}) < (CW + 1)'(DEPTH));
   assign accept    = in_valid && in_ready;
   assign push      = s1_valid;
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;

   assign is_arith            = (s1_cmd[2:1] == 2'b00);
   assign push_entry.result   = alu_result;
   assign push_entry.carryout = is_arith && alu_carryout;
   assign push_entry.zero     = alu_zero;
   assign push_entry.overflow = is_arith && alu_overflow;
   assign push_entry.tag      = s1_tag;

   // Stale queue contents stay hidden whenever the queue is empty
   assign head         = queue_mem[rd_ptr];
   assign out_result   = out_valid ? head.result : 32'd0;
   assign out_carryout = out_valid && head.carryout;
   assign out_zero     = out_valid && head.zero;
   assign out_overflow = out_valid && head.overflow;
   assign out_tag      = out_valid ? head.tag : 4'd0;

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_cmd <= in_cmd;
         s1_a   <= in_a;
         s1_b   <= in_b;
         s1_tag <= in_tag;
      end
      if (push) queue_mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid        <= 1'b0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         sticky_overflow <= 1'b0;
         op_count        <= 16'd0;
      end else begin
         s1_valid <= accept;
         if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            op_count <= op_count + 16'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && push_entry.overflow) sticky_overflow <= 1'b1;
         else if (sticky_clear)           sticky_overflow <= 1'b0;
      end
   end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage that wraps the combinational 32-bit `ALU` with valid/ready handshakes. Operands and command arrive from the decode/register-read stage and are captured into an operand register that drives `ALU`. Results and flags are buffered in a small in-order output queue for writeback. The block also keeps a sticky overflow flag and a completed-operation counter.

## Interface
- `DEPTH`, 4: output queue entries; power of two, ≥2; full throughput requires ≥3.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream offers an operation.
- `in_ready` out 1: stage accepts an operation this cycle.
- `in_cmd` in 3: ALU command: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR.
- `in_a`, `in_b` in 32 each: operands A and B.
- `in_tag` in 4: opaque ID, returned with the result.
- `out_valid` out 1: queue head is valid.
- `out_ready` in 1: downstream consumes the head.
- `out_result` out 32: result at the queue head.
- `out_carryout`, `out_zero`, `out_overflow` out 1 each: flags at the queue head.
- `out_tag` out 4: tag at the queue head.
- `sticky_overflow` out 1: set by any completed ADD/SUB that overflowed.
- `sticky_clear` in 1: clears `sticky_overflow`.
- `op_count` out 16: number of operations pushed into the queue; wraps.

## Operation
- Accept: `in_valid && in_ready` at an edge loads `in_cmd`, `in_a`, `in_b` and `in_tag` into the operand register and sets `s1_valid`.
- Operand register drives `ALU` (`.operandA`, `.operandB`, `.command`).
- Push: when `s1_valid` is set at an edge, the entry {result, flags, tag} is written to the queue tail. `s1_valid` clears at that edge unless a new accept occurs on the same edge.
- Flag rules applied before the push:
  - `zero` = (result == 0) for every command.
  - `carryout` and `overflow` pass through from `ALU` for cmd 000/001 and are forced to 0 for all other commands.
  - SLT result is exactly 0 or 1.
- Pop: `out_valid && out_ready` at an edge removes the head. Pop while empty has no effect.
- Credit rule: `in_ready = (count + s1_valid) < DEPTH`. This is a function of state only, with no combinational path from `out_ready`, and it guarantees a push never targets a full queue.
- Push and pop on the same edge leave `count` unchanged and are legal at any occupancy.
- Ordering: results leave in strict acceptance order.
- `sticky_overflow`:
  - Set on a push of an ADD/SUB entry whose overflow is 1.
  - Cleared when `sticky_clear` is high.
  - If set and clear coincide, set wins.
- `op_count` increments by 1 per push and wraps from FFFF to 0000.
- Reset:
  - Clears `s1_valid`, queue pointers, `count`, `sticky_overflow` and `op_count`.
  - All out_* data and flags read 0.
  - `out_valid` = 0; `in_ready` = 0 while `reset` is high and 1 on the first cycle after.
  - In-flight and queued operations are discarded. An accept attempted during reset is ignored.

## Timing
- Latency: an accept at edge N makes the result visible at the queue head after edge N+1 if the queue was empty, i.e. `out_valid` rises one cycle after the accept edge.
- Throughput: one operation per cycle when `out_ready` is held high and `DEPTH` ≥ 3.
- Under backpressure, at most `DEPTH` operations are held (queue plus operand register).
- Queue outputs come directly from the registered head entry; there is no combinational path from in_* to out_*.
- `sticky_overflow` and `op_count` update at the push edge and are visible in the same cycle `out_valid` shows the entry.

## Test plan
- ADD 0+0, tag 1 → after one cycle: `out_result` = 0, `zero` = 1, `carryout` = 0, `overflow` = 0, `out_tag` = 1, `op_count` = 1.
- SUB FFFFFFFF−FFFFFFFF, then SUB AAAAAAAA−55555555, back-to-back with `out_ready` = 1 → two consecutive outputs:
  - First: result 0, `carryout` 1, `zero` 1, `overflow` 0.
  - Second: result 55555555, `carryout` 1, `overflow` 1.
  - `sticky_overflow` = 1 after the second.
- XOR AAAAAAAA^33333333, then SLT with A = −600, B = 300 → results 99999999 and 00000001; `carryout`/`overflow` = 0 on both; `sticky_overflow` unchanged.
- `out_ready` = 0, `in_valid` held with tags 0..5 → exactly 4 accepts, then `in_ready` = 0. Raise `out_ready` → tags 0,1,2,3 appear in order, then 4 and 5 are accepted; no loss or duplication.
- `sticky_overflow` = 1, pulse `sticky_clear` on the same edge as pushing an overflowing SUB (01010101…−BBBBBBBB) → stays 1. A clear pulse on a later cycle → 0.
- Three operations queued under `out_ready` = 0, then `reset` for 1 cycle → `out_valid` = 0, `op_count` = 0, `sticky_overflow` = 0, `in_ready` = 1 next cycle; the next ADD 2+3 yields 5.
